// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - segmented ripple-carry adder pipeline with valid/ready flow control
// Optional signed-overflow output is built only when RCA_OVF_EN is defined.
module pipelined_rca #(
  parameter int WIDTH = 30,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = (WIDTH + SEG - 1) / SEG;

  logic             adv;
  logic             stg_v   [STAGES];
  logic [WIDTH-1:0] stg_a   [STAGES];
  logic [WIDTH-1:0] stg_b   [STAGES];
  logic [WIDTH-1:0] stg_sum [STAGES];
  logic             stg_c   [STAGES];

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign stg_v[0]   = in_valid && adv;
  assign stg_a[0]   = a;
  assign stg_b[0]   = sub ? ~b : b;
  assign stg_sum[0] = '0;
  assign stg_c[0]   = cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG - 1 : WIDTH - 1;

    logic [WIDTH-1:0] sum_d;
    logic             carry_d;

    // Ripple through this stage's segment; other sum bits pass through untouched.
    always_comb begin
      sum_d   = stg_sum[k];
      carry_d = stg_c[k];
      for (int i = LO; i <= HI; i++) begin
        sum_d[i] = stg_a[k][i] ^ stg_b[k][i] ^ carry_d;
        carry_d  = (stg_a[k][i] & stg_b[k][i]) | (carry_d & (stg_a[k][i] ^ stg_b[k][i]));
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic             valid_q;
      logic             carry_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] sum_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
        end else if (adv) begin
          valid_q <= stg_v[k];
        end
      end

      // Data of bubbles is don't-care, so these need no reset.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q     <= stg_a[k];
          b_q     <= stg_b[k];
          sum_q   <= sum_d;
          carry_q <= carry_d;
        end
      end

      assign stg_v[k+1]   = valid_q;
      assign stg_a[k+1]   = a_q;
      assign stg_b[k+1]   = b_q;
      assign stg_sum[k+1] = sum_q;
      assign stg_c[k+1]   = carry_q;
    end else begin : g_last
      logic             valid_q;
      logic             cout_q;
      logic [WIDTH-1:0] sum_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          sum_q   <= '0;
          cout_q  <= 1'b0;
        end else if (adv) begin
          valid_q <= stg_v[k];
          sum_q   <= sum_d;
          cout_q  <= carry_d;
        end
      end

      assign out_valid = valid_q;
      assign sum       = sum_q;
      assign cout      = cout_q;

`ifdef RCA_OVF_EN
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
      assign ovf_d = stg_a[k][WIDTH-1] ^ stg_b[k][WIDTH-1] ^ sum_d[WIDTH-1] ^ carry_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end

      assign ovf = ovf_q;
`endif
    end
  end

endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 The design SHALL provide parameter WIDTH, default 30, operand/sum width in bits (legal range 2..64).
REQ-002 The design SHALL provide parameter SEG, default 4, bits added per pipeline stage (legal range 1..WIDTH).
REQ-003 The design SHALL derive localparam STAGES = ceil(WIDTH/SEG); the last segment is WIDTH - (STAGES-1)*SEG bits wide.
REQ-004 clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in.
REQ-011 sub  input  1  1 = compute a + ~b + cin (cin driven 1 for a-b); 0 = a + b + cin.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sum  output  WIDTH  result bits.
REQ-015 cout  output  1  carry out of bit WIDTH-1 (in subtract mode, 0 = borrow).
REQ-016 ovf  output  1  signed overflow (present only with RCA_OVF_EN).

Function
REQ-017 Stage k (0..STAGES-1) SHALL add segment k of a and b' (b' = sub ? ~b : b) with carry from stage k-1 (cin for k=0) using ripple full adders, and register the segment sum and carry.
REQ-018 Each stage SHALL carry forward registered copies of not-yet-added upper operand segments and already-computed lower sum segments (skew/deskew), so sum is output aligned.
REQ-019 Latency SHALL be exactly STAGES cycles from accepted input beat to out_valid with no stall.
REQ-020 Global advance SHALL be adv = !out_valid | out_ready; in_ready SHALL equal adv; all stage registers hold when adv=0.
REQ-021 An input beat SHALL be accepted only when in_valid & in_ready; otherwise a bubble (valid=0) enters stage 0.
REQ-022 Throughput SHALL be one beat per cycle with out_ready held 1.
REQ-023 sum/cout/ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Results SHALL equal (a + (sub ? ~b : b) + cin) mod 2^(WIDTH+1), split as {cout,sum}, for all inputs including all-ones and wrap-around.
REQ-025 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated under any stall pattern.
REQ-026 Simultaneous output consumption and input acceptance in the same cycle with a full pipeline SHALL be supported without bubble insertion.
REQ-027 Data registers of invalid stages MAY hold any value; only valid bits and outputs are reset-defined.

Reset
REQ-028 On rst=1 at a clock edge, all stage valid bits SHALL clear; out_valid=0, sum=0, cout=0, ovf=0 the next cycle.
REQ-029 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-030 Reset asserted mid-operation SHALL discard all in-flight beats; no result from pre-reset beats SHALL appear afterward.

Configuration
REQ-031 Macro RCA_OVF_EN defined: port ovf present, ovf = carry-into-MSB XOR cout, registered with the final stage and aligned with sum.
REQ-032 Macro RCA_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 WIDTH=30,SEG=4: a=0x3FFFFFFF,b=0x00000001,cin=0,sub=0 -> after 8 cycles sum=0x00000000, cout=1 (ovf=0).
REQ-034 sub=1,cin=1,a=5,b=7 -> sum=0x3FFFFFFE, cout=0; a=7,b=5 -> sum=0x00000002, cout=1.
REQ-035 RCA_OVF_EN: a=0x1FFFFFFF,b=1,sub=0,cin=0 -> sum=0x20000000, ovf=1; a=0x20000000,b=0x3FFFFFFF -> ovf=1, cout=1.
REQ-036 Stream 20 beats back-to-back with out_ready toggled randomly -> 20 results in order, correct, stable while stalled, in_ready==(!out_valid|out_ready).
REQ-037 Load 5 beats, assert rst one cycle mid-flight -> out_valid=0 next cycle, no stale results ever emerge.
REQ-038 WIDTH=7,SEG=3 (STAGES=3, last segment 1 bit): random 1000 beats vs. reference model -> zero mismatches, latency 3.
